// File: rtl/ripple_sub_adder.sv
// ============================================================================
// Module   : ripple_sub_adder
// Purpose  : Registered N-bit ripple-carry adder/subtractor (d=1 subtracts).
//            Define RIPPLE_SUB_ADDER_OVF_EN to add the signed overflow output ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ripple_sub_adder #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         d,
   input  logic         in_valid,
   output logic [N-1:0] s,
   output logic         cout,
`ifdef RIPPLE_SUB_ADDER_OVF_EN
   output logic         ovf,
`endif
   output logic         out_valid
);

   logic [N-1:0] sum;
   logic [N-1:0] b_x;
   logic [N:0]   carry;

   // Full-adder chain; inverting b and injecting d as carry-in forms a + ~b + 1.
   always_comb begin
      sum      = '0;
      b_x      = '0;
      carry    = '0;
      carry[0] = d;
      for (int i = 0; i < N; i++) begin
         b_x[i]     = b[i] ^ d;
         sum[i]     = a[i] ^ b_x[i] ^ carry[i];
         carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
`ifdef RIPPLE_SUB_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s    <= sum;
            cout <= carry[N];
`ifdef RIPPLE_SUB_ADDER_OVF_EN
            ovf  <= carry[N] ^ carry[N-1];
`endif
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ripple_sub_adder.sv
// ============================================================================
// Module   : tb_ripple_sub_adder
// Purpose  : Directed self-checking bench for ripple_sub_adder with N=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ripple_sub_adder;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       d;
   logic       in_valid;
   logic [3:0] s;
   logic       cout;
   logic       out_valid;
`ifdef RIPPLE_SUB_ADDER_OVF_EN
   logic       ovf;
`endif

   int passed = 0;
   int total  = 0;

   ripple_sub_adder #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .d         (d),
      .in_valid  (in_valid),
      .s         (s),
      .cout      (cout),
`ifdef RIPPLE_SUB_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector tables: operand a, operand b, expected s, expected cout.
   logic [3:0] add_a [5] = '{4'b0001, 4'b1111, 4'b1111, 4'b0011, 4'b1010};
   logic [3:0] add_b [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110};
   logic [3:0] add_s [5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0111, 4'b0000};
   logic       add_c [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   logic [3:0] sub_a [6] = '{4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0101, 4'b0110};
   logic [3:0] sub_b [6] = '{4'b0001, 4'b0000, 4'b0111, 4'b1111, 4'b0011, 4'b0110};
   logic [3:0] sub_s [6] = '{4'b1111, 4'b0001, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
   logic       sub_c [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   logic [3:0] b2b_a [3] = '{4'b0111, 4'b1000, 4'b1100};
   logic [3:0] b2b_b [3] = '{4'b0111, 4'b1001, 4'b0100};
   logic       b2b_d [3] = '{1'b0, 1'b1, 1'b0};
   logic [3:0] b2b_s [3] = '{4'b1110, 4'b1111, 4'b0000};
   logic       b2b_c [3] = '{1'b0, 1'b0, 1'b1};

   // Drives one operation at the falling edge, then samples 1 ns after the rising edge.
   task automatic drive_op(input logic [3:0] op_a, input logic [3:0] op_b, input logic op_d);
      @(negedge clk);
      a        = op_a;
      b        = op_b;
      d        = op_d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      a        = 4'b1111;
      b        = 4'b1111;
      d        = 1'b0;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (s !== 4'b0000) $display("FAIL reset_s: got %b expected 0000", s);
      else passed++;
      total++;
      if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout);
      else passed++;
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic test_add();
      for (int i = 0; i < 5; i++) begin
         drive_op(add_a[i], add_b[i], 1'b0);
         total++;
         if (s !== add_s[i] || cout !== add_c[i] || out_valid !== 1'b1)
            $display("FAIL add_%0d: got s=%b cout=%b ov=%b expected s=%b cout=%b ov=1",
                     i, s, cout, out_valid, add_s[i], add_c[i]);
         else passed++;
      end
   endtask

   task automatic test_sub();
      for (int i = 0; i < 6; i++) begin
         drive_op(sub_a[i], sub_b[i], 1'b1);
         total++;
         if (s !== sub_s[i] || cout !== sub_c[i] || out_valid !== 1'b1)
            $display("FAIL sub_%0d: got s=%b cout=%b ov=%b expected s=%b cout=%b ov=1",
                     i, s, cout, out_valid, sub_s[i], sub_c[i]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive_op(b2b_a[i], b2b_b[i], b2b_d[i]);
         total++;
         if (s !== b2b_s[i] || cout !== b2b_c[i] || out_valid !== 1'b1)
            $display("FAIL b2b_%0d: got s=%b cout=%b ov=%b expected s=%b cout=%b ov=1",
                     i, s, cout, out_valid, b2b_s[i], b2b_c[i]);
         else passed++;
      end
   endtask

   // Last back-to-back result was s=0000, cout=1; it must persist with in_valid low.
   task automatic test_hold();
      @(negedge clk);
      in_valid = 1'b0;
      a        = 4'b0101;
      b        = 4'b0001;
      d        = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (s !== 4'b0000 || cout !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL hold_%0d: got s=%b cout=%b ov=%b expected s=0000 cout=1 ov=0",
                     i, s, cout, out_valid);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      drive_op(4'b1111, 4'b0001, 1'b0);
      total++;
      if (s !== 4'b0000 || cout !== 1'b1 || out_valid !== 1'b1)
         $display("FAIL prereset: got s=%b cout=%b ov=%b expected s=0000 cout=1 ov=1",
                  s, cout, out_valid);
      else passed++;
      drive_op(4'b0011, 4'b0001, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (s !== 4'b0000 || cout !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL async_reset: got s=%b cout=%b ov=%b expected s=0000 cout=0 ov=0",
                  s, cout, out_valid);
      else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (s !== 4'b0000 || cout !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL post_reset_idle_%0d: got s=%b cout=%b ov=%b expected zeros",
                     i, s, cout, out_valid);
         else passed++;
      end
      drive_op(4'b0001, 4'b0000, 1'b0);
      total++;
      if (s !== 4'b0001 || cout !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL first_after_reset: got s=%b cout=%b ov=%b expected s=0001 cout=0 ov=1",
                  s, cout, out_valid);
      else passed++;
   endtask

`ifdef RIPPLE_SUB_ADDER_OVF_EN
   task automatic test_ovf();
      drive_op(4'b0111, 4'b0001, 1'b0);
      total++;
      if (s !== 4'b1000 || ovf !== 1'b1)
         $display("FAIL ovf_add: got s=%b ovf=%b expected s=1000 ovf=1", s, ovf);
      else passed++;
      drive_op(4'b1000, 4'b0001, 1'b1);
      total++;
      if (s !== 4'b0111 || ovf !== 1'b1)
         $display("FAIL ovf_sub: got s=%b ovf=%b expected s=0111 ovf=1", s, ovf);
      else passed++;
      drive_op(4'b0011, 4'b0010, 1'b0);
      total++;
      if (s !== 4'b0101 || ovf !== 1'b0)
         $display("FAIL ovf_none: got s=%b ovf=%b expected s=0101 ovf=0", s, ovf);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_hold();
      test_async_reset();
`ifdef RIPPLE_SUB_ADDER_OVF_EN
      test_ovf();
`endif
      @(negedge clk);
      in_valid = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ripple_sub_adder.md
RIPPLE_SUB_ADDER -- requirements
Module: ripple_sub_adder

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand and result width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-004 SHALL have port a, input, N bits, meaning first operand (minuend when subtracting).
REQ-005 SHALL have port b, input, N bits, meaning second operand (subtrahend when subtracting).
REQ-006 SHALL have port d, input, 1 bit, meaning operation select: 0 = add, 1 = subtract.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning a, b and d are valid this cycle.
REQ-008 SHALL have port s, output, N bits, meaning registered result.
REQ-009 SHALL have port cout, output, 1 bit, meaning registered carry out of the MSB stage.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning s and cout hold a new result this cycle.

Function
REQ-011 SHALL compute the result with a ripple chain of N full-adder cells; stage i gets a[i], b[i] XOR d, and the carry from stage i-1; stage 0 carry-in = d.
REQ-012 SHALL give, for d=0, s = (a + b) mod 2^N and cout = carry out of bit N-1.
REQ-013 SHALL give, for d=1, s = (a - b) mod 2^N (two's complement) and cout = carry out of a + ~b + 1; cout=1 means no borrow (a >= b unsigned) and cout=0 means borrow.
REQ-014 SHALL register s and cout on the rising clk edge when in_valid=1; latency is exactly 1 cycle from input to output.
REQ-015 SHALL hold s and cout unchanged when in_valid=0.
REQ-016 SHALL drive out_valid to the value of in_valid registered one cycle earlier.
REQ-017 SHALL apply no backpressure; a new operation is accepted every cycle in_valid=1 (throughput 1/cycle).
REQ-018 SHALL wrap silently on overflow or underflow; no saturation.
REQ-019 SHALL treat operands as unsigned for cout; signed interpretation affects only the optional ovf output.

Reset
REQ-020 SHALL, while rst_n=0, immediately force s=0, cout=0, out_valid=0 (and ovf=0 when present), independent of clk.
REQ-021 SHALL discard any operation in flight when reset is asserted mid-operation; the first valid result after reset release appears one cycle after the first in_valid=1 sampled with rst_n=1.

Configuration
REQ-022 SHALL, when macro RIPPLE_SUB_ADDER_OVF_EN is defined, add an output port ovf (1 bit, registered with s, same latency and hold rules) giving signed two's-complement overflow = carry into MSB XOR carry out of MSB.
REQ-023 SHALL, when RIPPLE_SUB_ADDER_OVF_EN is not defined, omit the ovf port entirely and leave all other behaviour identical.

Verification (N=4)
REQ-024 SHALL pass: a=0001, b=0000, d=0, in_valid=1 -> next cycle s=0001, cout=0, out_valid=1.
REQ-025 SHALL pass: a=0000, b=0001, d=1 -> s=1111, cout=0 (borrow); a=0001, b=0000, d=1 -> s=0001, cout=1.
REQ-026 SHALL pass: a=1111, b=0001, d=0 -> s=0000, cout=1; a=1111, b=0010, d=0 -> s=0001, cout=1.
REQ-027 SHALL pass: a=1111, b=0111, d=1 -> s=1000, cout=1; a=0000, b=1111, d=1 -> s=0001, cout=0.
REQ-028 SHALL pass: with RIPPLE_SUB_ADDER_OVF_EN defined, a=0111, b=0001, d=0 -> s=1000, ovf=1; a=1000, b=0001, d=1 -> s=0111, ovf=1.
REQ-029 SHALL pass: rst_n driven low between clock edges while out_valid=1 -> s=0000, cout=0, out_valid=0 immediately; in_valid=0 for several cycles after release -> outputs stay 0.
